// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - two-port round-robin arbiter in front of a single-port memory
//
// Shares one ideal memory between the instruction-fetch port (IF, read-only)
// and the load/store port (DM, read/write), one transaction at a time, with a
// programmable number of ACCESS cycles per transaction.
//
// Ports:
//   clk, resetn                     clock, asynchronous active-low reset
//   if_req_valid/ready, if_addr     IF read request channel (byte address)
//   if_resp_valid/ready, if_rdata   IF read response channel
//   dm_req_valid/ready, dm_addr,    DM request channel (dm_wren=1 store)
//   dm_wren, dm_wdata
//   dm_resp_valid/ready, dm_rdata   DM response channel (rdata 0 on store ack)
//   mem_waddr, mem_wren, mem_wdata  memory write port
//   mem_raddr, mem_rden, mem_rdata  memory read port 1 (combinational read)
module mem_port_arbiter #(
  parameter int ADDR_WIDTH = 10,
  parameter int LATENCY    = 2
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  if_req_valid,
  output logic                  if_req_ready,
  input  logic [31:0]           if_addr,
  output logic                  if_resp_valid,
  input  logic                  if_resp_ready,
  output logic [31:0]           if_rdata,
  input  logic                  dm_req_valid,
  output logic                  dm_req_ready,
  input  logic [31:0]           dm_addr,
  input  logic                  dm_wren,
  input  logic [31:0]           dm_wdata,
  output logic                  dm_resp_valid,
  input  logic                  dm_resp_ready,
  output logic [31:0]           dm_rdata,
  output logic [ADDR_WIDTH-1:0] mem_waddr,
  output logic [ADDR_WIDTH-1:0] mem_raddr,
  output logic                  mem_wren,
  output logic                  mem_rden,
  output logic [31:0]           mem_wdata,
  input  logic [31:0]           mem_rdata
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  state_t                  state, state_nxt;
  logic                    prio_dm;     // 1: DM wins the next tie
  logic                    owner_dm;
  logic                    wr_q;
  logic [ADDR_WIDTH-1:0]   widx_q;
  logic [31:0]             wdata_q;
  logic [3:0]              cnt_q;
  logic [31:0]             if_rdata_q, dm_rdata_q;
  logic                    cnt_done;
  logic                    resp_taken;

  // Only the word index matters; byte offset and bits above the memory wrap.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{if_addr[31:ADDR_WIDTH+2], if_addr[1:0],
                              dm_addr[31:ADDR_WIDTH+2], dm_addr[1:0]};

  assign cnt_done   = (cnt_q == 4'd0);
  assign resp_taken = owner_dm ? dm_resp_ready : if_resp_ready;

  // State register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (if_req_ready || dm_req_ready) state_nxt = ACCESS;
      ACCESS:  if (cnt_done)                     state_nxt = RESP;
      RESP:    if (resp_taken)                   state_nxt = IDLE;
      default:                                   state_nxt = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    if_req_ready  = 1'b0;
    dm_req_ready  = 1'b0;
    if_resp_valid = 1'b0;
    dm_resp_valid = 1'b0;
    mem_waddr     = '0;
    mem_raddr     = '0;
    mem_wren      = 1'b0;
    mem_rden      = 1'b0;
    mem_wdata     = '0;
    case (state)
      IDLE: begin
        // resetn gating keeps ready low while reset is held with valid high
        if (resetn) begin
          if (if_req_valid && dm_req_valid) begin
            dm_req_ready = prio_dm;
            if_req_ready = !prio_dm;
          end else begin
            if_req_ready = if_req_valid;
            dm_req_ready = dm_req_valid;
          end
        end
      end
      ACCESS: begin
        mem_raddr = widx_q;
        mem_waddr = widx_q;
        mem_wdata = wdata_q;
        mem_rden  = !wr_q;
        mem_wren  = wr_q && cnt_done;   // single write pulse in the last cycle
      end
      RESP: begin
        if_resp_valid = !owner_dm;
        dm_resp_valid = owner_dm;
      end
      default: ;
    endcase
  end

  // Transaction datapath
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      prio_dm    <= 1'b1;
      owner_dm   <= 1'b0;
      wr_q       <= 1'b0;
      widx_q     <= '0;
      wdata_q    <= '0;
      cnt_q      <= '0;
      if_rdata_q <= '0;
      dm_rdata_q <= '0;
    end else begin
      if (state == IDLE && (if_req_ready || dm_req_ready)) begin
        owner_dm <= dm_req_ready;
        wr_q     <= dm_req_ready && dm_wren;
        widx_q   <= dm_req_ready ? dm_addr[ADDR_WIDTH+1:2] : if_addr[ADDR_WIDTH+1:2];
        wdata_q  <= dm_req_ready ? dm_wdata : 32'd0;
        cnt_q    <= CNT_INIT;
        prio_dm  <= if_req_ready;       // the other port wins the next tie
      end else if (state == ACCESS) begin
        if (cnt_done) begin
          if (owner_dm) dm_rdata_q <= wr_q ? 32'd0 : mem_rdata;
          else          if_rdata_q <= mem_rdata;
        end else begin
          cnt_q <= cnt_q - 4'd1;
        end
      end
    end
  end

  assign if_rdata = if_rdata_q;
  assign dm_rdata = dm_rdata_q;

endmodule
